// File: rtl/pipeline_sink.sv
// pipeline_sink: receive end of the DSP pipeline; buffers beats in a FIFO
// and re-presents them on a ready/valid port. Optional: PIPELINE_SINK_STATS_EN.
module pipeline_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic                       clear_err,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
`ifdef PIPELINE_SINK_STATS_EN
    output logic [31:0]                beat_count,
    output logic [31:0]                drop_count,
`endif
    output logic [1:0]                 sink_state
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACTIVE = 2'b01,
        S_ERR    = 2'b11
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    state_e           state_q, state_d;

    logic [PTR_W-1:0] level_q;
    logic [PTR_W-1:0] level_d;
    logic             full_w;
    logic             empty_w;
    logic             wr;
    logic             rd;
    logic             ovf_evt;

    // Occupancy and handshake qualification from the current pointers.
    always_comb begin
        level_q = wr_ptr_q - rd_ptr_q;
        full_w  = (level_q == DEPTH_L);
        empty_w = (level_q == '0);
        rd      = !empty_w && out_ready && !flush;
        wr      = enable && in_valid && !flush && (!full_w || rd);
        ovf_evt = enable && in_valid && full_w && !rd && !flush;
    end

    // Pointer and sticky-overflow next state; flush empties by catching rd up.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + ONE_P;
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (rd) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clear_err) begin
            overflow_d = 1'b0;
        end
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // State follows the next-cycle level and overflow values.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (overflow_d) begin
                    state_d = S_ERR;
                end else if (level_d != '0) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (overflow_d) begin
                    state_d = S_ERR;
                end else if (level_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (!overflow_d) begin
                    state_d = (level_d == '0) ? S_IDLE : S_ACTIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    // Storage array; contents need no reset since the pointers guard them.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
        end
    end

`ifdef PIPELINE_SINK_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Saturating event counters.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (wr && (beat_cnt_q != 32'hFFFF_FFFF)) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
        if (ovf_evt && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    // Counters clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign beat_count = beat_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

    // Output port drive; head word forced to zero when nothing is stored.
    always_comb begin
        out_valid  = !empty_w;
        out_data   = empty_w ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
        level      = level_q;
        full       = full_w;
        empty      = empty_w;
        overflow   = overflow_q;
        sink_state = state_q;
    end

endmodule
